// File: rtl/dadd_arbiter.sv
// Round-robin arbiter that shares one double_adder among N_REQ requesters.
// Optional zero-operand bypass: define DADD_ARB_ZERO_BYPASS_EN.
module dadd_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req_stb,
   input  logic [64*N_REQ-1:0]   req_a,
   input  logic [64*N_REQ-1:0]   req_b,
   output logic [N_REQ-1:0]      req_ack,
   output logic [63:0]           rsp_z,
   output logic [ID_W-1:0]       rsp_id,
   output logic                  rsp_stb,
   input  logic                  rsp_ack,
   output logic [63:0]           adder_a,
   output logic                  adder_a_stb,
   input  logic                  adder_a_ack,
   output logic [63:0]           adder_b,
   output logic                  adder_b_stb,
   input  logic                  adder_b_ack,
   input  logic [63:0]           adder_z,
   input  logic                  adder_z_stb,
   output logic                  adder_z_ack,
   output logic                  busy
);

   localparam int unsigned DW = 64;

   typedef enum logic [2:0] {
      IDLE,
      SEND_A,
      SEND_B,
      WAIT_Z,
      RESP
   } state_t;

   state_t          state;
   logic [ID_W-1:0] last_grant;
   logic [ID_W-1:0] gnt_idx;
   logic [ID_W-1:0] cand;
   logic            gnt_found;
   logic [DW-1:0]   a_arr [N_REQ];
   logic [DW-1:0]   b_arr [N_REQ];
   logic [DW-1:0]   sel_a;
   logic [DW-1:0]   sel_b;

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign a_arr[g] = req_a[DW*g +: DW];
      assign b_arr[g] = req_b[DW*g +: DW];
   end

   // First pending requester after last_grant, with wrap.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         cand = ID_W'((32'(last_grant) + i) % N_REQ);
         if (!gnt_found && req_stb[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   assign sel_a = a_arr[gnt_idx];
   assign sel_b = b_arr[gnt_idx];

`ifdef DADD_ARB_ZERO_BYPASS_EN
   logic          a_zero;
   logic          b_zero;
   logic [DW-1:0] byp_z;

   // A zero operand makes the sum the other operand; +0 + -0 gives +0.
   always_comb begin
      a_zero = (sel_a[DW-2:0] == '0);
      b_zero = (sel_b[DW-2:0] == '0);
      if (a_zero && b_zero) begin
         byp_z = {sel_a[DW-1] & sel_b[DW-1], (DW-1)'(0)};
      end else if (a_zero) begin
         byp_z = sel_b;
      end else begin
         byp_z = sel_a;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         last_grant  <= ID_W'(N_REQ - 1);
         req_ack     <= '0;
         rsp_z       <= '0;
         rsp_id      <= '0;
         rsp_stb     <= 1'b0;
         adder_a     <= '0;
         adder_a_stb <= 1'b0;
         adder_b     <= '0;
         adder_b_stb <= 1'b0;
         adder_z_ack <= 1'b0;
         busy        <= 1'b0;
      end else begin
         req_ack <= '0;
         case (state)
            IDLE: begin
               if (gnt_found) begin
                  adder_a    <= sel_a;
                  adder_b    <= sel_b;
                  rsp_id     <= gnt_idx;
                  last_grant <= gnt_idx;
                  req_ack    <= N_REQ'(1) << gnt_idx;
                  busy       <= 1'b1;
`ifdef DADD_ARB_ZERO_BYPASS_EN
                  if (a_zero || b_zero) begin
                     rsp_z   <= byp_z;
                     rsp_stb <= 1'b1;
                     state   <= RESP;
                  end else begin
                     adder_a_stb <= 1'b1;
                     state       <= SEND_A;
                  end
`else
                  adder_a_stb <= 1'b1;
                  state       <= SEND_A;
`endif
               end
            end
            SEND_A: begin
               if (adder_a_stb && adder_a_ack) begin
                  adder_a_stb <= 1'b0;
                  adder_b_stb <= 1'b1;
                  state       <= SEND_B;
               end
            end
            SEND_B: begin
               if (adder_b_stb && adder_b_ack) begin
                  adder_b_stb <= 1'b0;
                  adder_z_ack <= 1'b1;
                  state       <= WAIT_Z;
               end
            end
            WAIT_Z: begin
               if (adder_z_stb && adder_z_ack) begin
                  rsp_z       <= adder_z;
                  adder_z_ack <= 1'b0;
                  rsp_stb     <= 1'b1;
                  state       <= RESP;
               end
            end
            RESP: begin
               if (rsp_ack) begin
                  rsp_stb <= 1'b0;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
